// File: rtl/memoria_datos_pkg.sv
// memoria_datos_pkg: shared size encodings and dump FSM states for the MEM-stage data memory
package memoria_datos_pkg;
  localparam logic [1:0] TAM_WORD = 2'b00;
  localparam logic [1:0] TAM_BYTE = 2'b01;
  localparam logic [1:0] TAM_HALF = 2'b10;
  typedef enum logic [1:0] {IDLE, LEER, ENVIAR, FIN} estado_t;
endpackage

// File: rtl/memoria_datos_if.sv
// memoria_datos_if: load/store port and debug dump handshake of the data memory
interface memoria_datos_if #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 32,
  parameter int TNBITS = 2
);
  localparam int AW = $clog2(CELDAS);
  logic              i_MemRead;
  logic              i_MemWrite;
  logic [NBITS-1:0]  i_Direccion;
  logic [NBITS-1:0]  i_DatoEscribir;
  logic [TNBITS-1:0] i_Tamano;
  logic [NBITS-1:0]  o_Dato;
  logic              o_ErrorAlineacion;
  logic              i_DebugStart;
  logic              i_DebugReady;
  logic [NBITS-1:0]  o_DebugDato;
  logic [AW-1:0]     o_DebugDirec;
  logic              o_DebugValid;
  logic              o_DebugFin;
  modport master (
    output i_MemRead, i_MemWrite, i_Direccion, i_DatoEscribir, i_Tamano, i_DebugStart, i_DebugReady,
    input  o_Dato, o_ErrorAlineacion, o_DebugDato, o_DebugDirec, o_DebugValid, o_DebugFin
  );
  modport slave (
    input  i_MemRead, i_MemWrite, i_Direccion, i_DatoEscribir, i_Tamano, i_DebugStart, i_DebugReady,
    output o_Dato, o_ErrorAlineacion, o_DebugDato, o_DebugDirec, o_DebugValid, o_DebugFin
  );
endinterface

// File: rtl/memoria_datos_generador_bytes.sv
// memoria_datos_generador_bytes: byte enables, lane-replicated store data and misalignment flag
module memoria_datos_generador_bytes
  import memoria_datos_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int TNBITS = 2
) (
  input  logic [1:0]        offset_i,
  input  logic [TNBITS-1:0] tamano_i,
  input  logic [NBITS-1:0]  dato_i,
  output logic [3:0]        be_o,
  output logic [NBITS-1:0]  wdata_o,
  output logic              error_o
);
  // Replicating the data across lanes lets the enables alone pick the target bytes
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = dato_i;
    error_o = 1'b0;
    case (tamano_i)
      TAM_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{dato_i[7:0]}};
      end
      TAM_HALF: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{dato_i[15:0]}};
        error_o = offset_i[0];
      end
      TAM_WORD: begin
        be_o    = 4'b1111;
        error_o = |offset_i;
      end
      default: error_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/memoria_datos.sv
// memoria_datos: byte-addressable data memory with right-aligned loads and a debug dump engine
module memoria_datos
  import memoria_datos_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 32,
  parameter int TNBITS = 2
) (
  input logic            i_clk,
  input logic            i_reset,
  memoria_datos_if.slave bus
);
  localparam int AW = $clog2(CELDAS);
  logic [NBITS-1:0] mem_q [CELDAS];
  logic [3:0]       be;
  logic [NBITS-1:0] wdata, palabra, dato_d, dato_q, dbg_dato_q;
  logic             desal, idle, we, re, err_d, err_q, valid_q, fin_q;
  logic [AW-1:0]    idx, cnt_q, direc_q;
  logic [1:0]       off;
  estado_t          estado_q;
  logic             unused_dir;
  assign idx        = bus.i_Direccion[AW+1:2];
  assign off        = bus.i_Direccion[1:0];
  assign unused_dir = ^bus.i_Direccion[NBITS-1:AW+2];
  assign idle       = estado_q == IDLE;
  assign we         = idle & bus.i_MemWrite & ~desal;
  assign re         = idle & bus.i_MemRead & ~bus.i_MemWrite & ~desal;
  assign err_d      = idle & (bus.i_MemRead | bus.i_MemWrite) & desal;
  assign palabra    = mem_q[idx];
  memoria_datos_generador_bytes #(.NBITS(NBITS), .TNBITS(TNBITS)) generador_bytes (
    .offset_i(off),
    .tamano_i(bus.i_Tamano),
    .dato_i  (bus.i_DatoEscribir),
    .be_o    (be),
    .wdata_o (wdata),
    .error_o (desal)
  );
  // Right-align the addressed byte/halfword so the load filter only has to extend it
  always_comb
    dato_d = bus.i_Tamano == TAM_BYTE ? NBITS'(palabra[{off, 3'b000} +: 8]) :
             bus.i_Tamano == TAM_HALF ? NBITS'(palabra[{off[1], 4'b0000} +: 16]) : palabra;
  // Lane-masked store; lanes without an enable keep their contents
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)
      for (int i = 0; i < CELDAS; i++) mem_q[i] <= '0;
    else if (we)
      for (int b = 0; b < 4; b++) if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  // Load data holds unless a valid plain read arrives; the error flag lasts one cycle
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      dato_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (re) dato_q <= dato_d;
    end
  // Dump engine: fetch a word, then present it until the debug unit accepts it
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      estado_q   <= IDLE;
      cnt_q      <= '0;
      dbg_dato_q <= '0;
      direc_q    <= '0;
      valid_q    <= 1'b0;
      fin_q      <= 1'b0;
    end else case (estado_q)
      IDLE: if (bus.i_DebugStart) begin
        cnt_q    <= '0;
        estado_q <= LEER;
      end
      LEER: begin
        dbg_dato_q <= mem_q[cnt_q];
        direc_q    <= cnt_q;
        valid_q    <= 1'b1;
        estado_q   <= ENVIAR;
      end
      ENVIAR: if (bus.i_DebugReady) begin
        valid_q <= 1'b0;
        if (cnt_q == AW'(CELDAS - 1)) begin
          fin_q    <= 1'b1;
          estado_q <= FIN;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          estado_q <= LEER;
        end
      end
      default: begin
        fin_q    <= 1'b0;
        estado_q <= IDLE;
      end
    endcase
  assign bus.o_Dato            = dato_q;
  assign bus.o_ErrorAlineacion = err_q;
  assign bus.o_DebugDato       = dbg_dato_q;
  assign bus.o_DebugDirec      = direc_q;
  assign bus.o_DebugValid      = valid_q;
  assign bus.o_DebugFin        = fin_q;
endmodule

// File: doc/memoria_datos.md
# memoria_datos

Synchronous byte-addressable data memory for the MIPS MEM stage, directly upstream of the load filter. It performs lane-correct byte, halfword and word stores. On loads it returns the addressed word right-aligned, so the selected byte or halfword sits in bits [7:0] or [15:0] for the filter to extend. A sequential dump engine streams the whole memory to the debug unit over a valid/ready handshake.

## Interface
- NBITS, 32, data and address width
- CELDAS, 32, number of 32-bit words (power of two)
- TNBITS, 2, width of the size selector
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_MemRead  in  1  load request this cycle
- i_MemWrite  in  1  store request this cycle
- i_Direccion  in  NBITS  byte address
- i_DatoEscribir  in  NBITS  store data, right-aligned
- i_Tamano  in  TNBITS  access size: 00 word, 01 byte, 10 halfword, 11 invalid
- o_Dato  out  NBITS  registered load data, right-aligned, upper bits zero
- o_ErrorAlineacion  out  1  registered one-cycle misalignment/invalid-size flag
- i_DebugStart  in  1  start memory dump (pulse)
- i_DebugReady  in  1  debug unit accepts o_DebugDato
- o_DebugDato  out  NBITS  dumped word
- o_DebugDirec  out  log2(CELDAS)  word index of o_DebugDato
- o_DebugValid  out  1  o_DebugDato is valid
- o_DebugFin  out  1  one-cycle pulse after the last word is accepted

## Operation
- Word index is i_Direccion[log2(CELDAS)+1:2]. Higher address bits are ignored, so addresses wrap.
- Offset is i_Direccion[1:0]. An access is misaligned in three cases: halfword with offset[0]=1; word with offset≠0; size 11.
- A misaligned or invalid access sets o_ErrorAlineacion for the next cycle. Its store is suppressed and its load leaves o_Dato unchanged.
- Store, byte: lane offset ← i_DatoEscribir[7:0].
- Store, halfword: lanes {offset[1],1} and {offset[1],0} ← i_DatoEscribir[15:0].
- Store, word: all lanes. Untouched lanes keep their value.
- Load, byte: o_Dato ← {24'b0, word >> 8·offset [7:0]}.
- Load, halfword: o_Dato ← {16'b0, word >> 16·offset[1] [15:0]}.
- Load, word: o_Dato ← word.
- i_MemRead and i_MemWrite both high: the store executes and o_Dato holds.
- With no read, o_Dato holds its last value.
- Dump FSM states: IDLE, LEER, ENVIAR, FIN.
  - IDLE: i_DebugStart → LEER with counter 0.
  - LEER: o_DebugDato ← mem[counter], o_DebugDirec ← counter → ENVIAR.
  - ENVIAR: o_DebugValid=1. Hold data until i_DebugReady=1. Then, if counter=CELDAS-1, → FIN; else counter+1 → LEER.
  - FIN: o_DebugFin=1 → IDLE.
  - i_DebugStart outside IDLE is ignored.
- While the FSM is not IDLE, i_MemRead and i_MemWrite are ignored: no store, o_Dato holds, no error flag. The debug unit halts the pipeline during a dump.

## Timing
- Reset values:
  - memory contents all zero
  - o_Dato = 0
  - o_ErrorAlineacion = 0
  - o_DebugDato = 0
  - o_DebugDirec = 0
  - o_DebugValid = 0
  - o_DebugFin = 0
  - FSM = IDLE, counter = 0
- Load latency is 1 cycle: o_Dato updates on the edge that samples i_MemRead.
- Store commits on the sampling edge. A load of the same address in the next cycle returns the new data.
- The dump costs 2 cycles per word with i_DebugReady held high, so CELDAS=32 takes 64 cycles plus 1 FIN cycle.
- Dropping i_DebugReady stalls the FSM in ENVIAR with data and index stable.
- Reset asserted mid-dump forces IDLE and drops o_DebugValid asynchronously. The dump does not resume.

## Structure
- Shared package holds:
  - size encodings TAM_WORD=2'b00, TAM_BYTE=2'b01, TAM_HALF=2'b10, identical to the load filter encoding;
  - dump FSM state encodings.
- One combinational sub-module, generador_bytes, computes from (offset, size, store data):
  - the 4-bit byte-enable;
  - lane-replicated write data;
  - the misalignment flag.

## Test plan
- Word store 0xDEADBEEF @0x10, byte load @0x11 → o_Dato=0x000000BE one cycle later, o_ErrorAlineacion=0.
- Byte store 0x7F @0x13 over that word, word load @0x10 → 0x7FADBEEF. Halfword load @0x12 → 0x00007FAD.
- Halfword store @0x05 → o_ErrorAlineacion=1 for one cycle, word @0x04 unchanged. Word load @0x06 → o_Dato holds its previous value.
- Address wrap with CELDAS=32: word store 0x12345678 @0x80, load @0x00 → 0x12345678.
- Dump with i_DebugReady toggling 1/0 (one cycle each):
  - words arrive in index order 0..31 with the correct contents;
  - data is stable while stalled;
  - o_DebugFin pulses exactly once after index 31.
- Reset asserted at index 7 of a dump → o_DebugValid=0 immediately, FSM=IDLE, all memory reads 0. A new i_DebugStart restarts at index 0.
